fetch_stage_reg: RTL
====================

FETCH_STAGE_REG -- requirements
Module: fetch_stage_reg

Interface
Parameters:
REQ-001 SHALL provide parameter OPC_W, default 5, opcode field width.
REQ-002 SHALL provide parameter REG_W, default 4, width of each of s1, s2 and dest.
REQ-003 SHALL provide parameter IMM_W, default 32, immediate field width.
Ports:
REQ-004 SHALL have clk_r  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have reset_n_r  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have in_valid_r  input  1  upstream instruction valid.
REQ-007 SHALL have in_ready_r  output  1  block can accept; registered.
REQ-008 SHALL have opcode_in_f_r / s1_in_f_r / s2_in_f_r / dest_in_f_r / ime_data_in_f_r  input  OPC_W / REG_W / REG_W / REG_W / IMM_W  upstream payload.
REQ-009 SHALL have flush_r  input  1  synchronous discard of all held entries.
REQ-010 SHALL have out_valid_r  output  1  downstream payload valid; registered.
REQ-011 SHALL have out_ready_r  input  1  downstream can accept.
REQ-012 SHALL have opcode_out_f_r / s1_out_f_r / s2_out_f_r / dest_out_f_r / ime_data_out_f_r  output  widths as REQ-008  payload to decode.
REQ-013 SHALL have occ_r  output  2  entries held (0..2).

Function
REQ-014 SHALL be a 2-entry skid buffer: one output register (head) plus one skid register; states EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-015 SHALL accept (push) when in_valid_r && in_ready_r, and pop when out_valid_r && out_ready_r, both on the same edge.
REQ-016 SHALL drive in_ready_r = (occ != 2) and out_valid_r = (occ != 0), both from registers only, with no combinational path from any input to any output.
REQ-017 SHALL transition: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE (new payload into head); FULL+pop -> ONE (skid moves to head); all other combinations hold the state.
REQ-018 SHALL present a payload pushed into an EMPTY block on the outputs one cycle after acceptance (latency 1).
REQ-019 SHALL deliver payloads in strict acceptance order, with no loss or duplication.
REQ-020 SHALL hold the head payload stable while out_valid_r=1 and out_ready_r=0.
REQ-021 SHALL, on flush_r=1, set occ to 0 and zero all payload outputs on the next edge; flush overrides a push or pop in the same cycle, and the pushed payload is discarded.
REQ-022 SHALL, when a pop empties the block without a push, retain the last payload on the outputs with out_valid_r=0.

Reset
REQ-023 SHALL, while reset_n_r=0 and regardless of clk_r, force occ_r=0, in_ready_r=0, out_valid_r=0 and all payload outputs and the skid register to 0.
REQ-024 SHALL drive in_ready_r=1 from the first clock edge after reset_n_r deasserts, and SHALL discard any entries held if reset asserts mid-operation.

Configuration
REQ-025 SHALL, with macro FETCH_STAGE_REG_PERF_EN defined, add output stall_cnt_r (16 bits) that increments by 1 each cycle with out_valid_r=1 and out_ready_r=0, saturates at 16'hFFFF, and resets to 0 on reset_n_r=0 but not on flush_r.
REQ-026 SHALL, without FETCH_STAGE_REG_PERF_EN, omit stall_cnt_r entirely, with no port and no logic.

Verification
REQ-027 SHALL cover reset: assert reset_n_r mid-FULL -> immediately occ_r=0, out_valid_r=0, all payloads 0; one edge after release -> in_ready_r=1.
REQ-028 SHALL cover pass-through: out_ready_r=1, push opcode=5'h03, ime=32'hDEADBEEF -> next cycle out_valid_r=1 with the same fields; occ_r stays <=1 under continuous streaming.
REQ-029 SHALL cover backpressure: out_ready_r=0, push A, B, then offer C -> occ_r=2, in_ready_r=0, C is not accepted; raise out_ready_r -> A, B, C are delivered in order.
REQ-030 SHALL cover flush: FULL with flush_r=1 and in_valid_r=1 in the same cycle -> next cycle occ_r=0, out_valid_r=0, payload 0, and the pushed data never appears.
REQ-031 SHALL cover push+pop in ONE: head A, push B with out_ready_r=1 -> next cycle head=B, occ_r=1.
REQ-032 SHALL cover PERF_EN: hold out_valid_r=1 and out_ready_r=0 for 10 cycles -> stall_cnt_r=10; preload near max -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/fetch_stage_reg.sv
// fetch_stage_reg: two-entry skid buffer between fetch and decode.
// The head register drives the payload outputs directly; a second skid
// register catches one more instruction while decode stalls, so both
// valid/ready handshakes are fully registered.
// Optional feature: define FETCH_STAGE_REG_PERF_EN to add stall_cnt_r,
// a saturating count of cycles where decode stalled a valid head.
module fetch_stage_reg #(
  parameter int OPC_W = 5,
  parameter int REG_W = 4,
  parameter int IMM_W = 32
) (
  input  logic             clk_r,
  input  logic             reset_n_r,
  input  logic             in_valid_r,
  output logic             in_ready_r,
  input  logic [OPC_W-1:0] opcode_in_f_r,
  input  logic [REG_W-1:0] s1_in_f_r,
  input  logic [REG_W-1:0] s2_in_f_r,
  input  logic [REG_W-1:0] dest_in_f_r,
  input  logic [IMM_W-1:0] ime_data_in_f_r,
  input  logic             flush_r,
  output logic             out_valid_r,
  input  logic             out_ready_r,
  output logic [OPC_W-1:0] opcode_out_f_r,
  output logic [REG_W-1:0] s1_out_f_r,
  output logic [REG_W-1:0] s2_out_f_r,
  output logic [REG_W-1:0] dest_out_f_r,
  output logic [IMM_W-1:0] ime_data_out_f_r,
  output logic [1:0]       occ_r
`ifdef FETCH_STAGE_REG_PERF_EN
  ,
  output logic [15:0]      stall_cnt_r
`endif
);

  localparam int PW = OPC_W + 3 * REG_W + IMM_W;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] head_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] in_pl;
  logic          push;
  logic          pop;
  logic          head_from_in;
  logic          head_from_skid;
  logic          skid_load;

  assign in_pl = {opcode_in_f_r, s1_in_f_r, s2_in_f_r, dest_in_f_r, ime_data_in_f_r};
  assign {opcode_out_f_r, s1_out_f_r, s2_out_f_r, dest_out_f_r, ime_data_out_f_r} = head_q;
  assign occ_r = state_q;

  assign push = in_valid_r && in_ready_r;
  assign pop  = out_valid_r && out_ready_r;

  // Next occupancy and which payload register loads what; flush wins over everything.
  always_comb begin
    state_d        = state_q;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_r) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d      = ONE;
            head_from_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_from_in = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State plus registered handshake flags, so no input reaches an output combinationally.
  always_ff @(posedge clk_r or negedge reset_n_r) begin
    if (!reset_n_r) begin
      state_q     <= EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_r  <= (state_d != FULL);
      out_valid_r <= (state_d != EMPTY);
    end
  end

  // Payload registers; the head keeps its last value when the buffer drains.
  always_ff @(posedge clk_r or negedge reset_n_r) begin
    if (!reset_n_r) begin
      head_q <= '0;
      skid_q <= '0;
    end else if (flush_r) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_from_in) begin
        head_q <= in_pl;
      end else if (head_from_skid) begin
        head_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_pl;
      end
    end
  end

`ifdef FETCH_STAGE_REG_PERF_EN
  // Saturating count of cycles where decode held off a valid head; flush leaves it alone.
  always_ff @(posedge clk_r or negedge reset_n_r) begin
    if (!reset_n_r) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_r && !out_ready_r && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end
`endif

endmodule
